// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID boot checker.
// - sysid_state_t : boot checker FSM states
// - SYSID_ADDR_*  : word addresses inside the system-ID slave
// - SYSID_DEFAULT_*: default ID / build timestamp, shared with the slave generator
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_DONE    = 3'd5
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID        = 32'hDEADBEEF;
  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'h5B95D975;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Saturating per-access timeout counter for simple bus masters.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   clear        : zero the count (wins over enable)
//   enable       : count this cycle
//   limit        : number of enabled cycles allowed per access
//   hit          : this enabled cycle is the one in which the count reaches limit
module sysid_timeout_ctr #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] count;
  logic [W:0]   count_inc;

  // One extra bit so the compare is correct even at the saturation value.
  assign count_inc = {1'b0, count} + {{W{1'b0}}, 1'b1};
  assign hit       = enable && (count_inc >= {1'b0, limit});

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {W{1'b1}})) begin
      count <= count_inc[W-1:0];
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that reads the system-ID slave (word 0 = ID,
// word 1 = build timestamp) after reset and reports whether the image matches.
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   start               : pulse to (re)run the sequence; ignored while busy
//   avm_address/avm_read: read request towards the system-ID slave
//   avm_waitrequest     : slave stall
//   avm_readdatavalid   : read data valid (only with USE_READDATAVALID=1)
//   avm_readdata        : read data
//   busy                : sequence in progress
//   done                : sequence finished, held until next start or reset
//   pass/fail/timeout   : result flags, valid while done=1
//   sysid_id/sysid_timestamp : captured words 0 and 1
//
// Handshake: a read is accepted in the cycle where avm_read=1 and
// avm_waitrequest=0; until then avm_read and avm_address are held stable.
// Without readdatavalid the data is taken in the accept cycle; with it the
// request drops after the accept and the data is taken when
// avm_readdatavalid=1. Only one read is ever outstanding.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter bit          USE_READDATAVALID  = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] sysid_id,
  output logic [31:0] sysid_timestamp
);

  localparam logic [15:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];

  sysid_state_t state;
  sysid_state_t state_next;

  logic first_cycle;  // high only in the first cycle after reset release
  logic accept;
  logic launch;
  logic cap_id;
  logic cap_ts;
  logic abort;
  logic to_hit;
  logic ts_ok;
  logic run_ok;

  assign avm_read    = (state == ST_REQ_ID) || (state == ST_REQ_TS);
  assign avm_address = ((state == ST_REQ_TS) || (state == ST_WAIT_TS)) ? SYSID_ADDR_TS
                                                                       : SYSID_ADDR_ID;
  assign busy        = (state == ST_REQ_ID) || (state == ST_WAIT_ID) ||
                       (state == ST_REQ_TS) || (state == ST_WAIT_TS);
  assign done        = (state == ST_DONE);
  assign accept      = avm_read && !avm_waitrequest;

  // The counter restarts for each access: on launch and on the ID capture.
  sysid_timeout_ctr #(
    .W(16)
  ) u_timeout_ctr (
    .clock  (clock),
    .reset  (reset),
    .clear  (launch || cap_id),
    .enable (busy),
    .limit  (TIMEOUT_LIMIT),
    .hit    (to_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A capture in the limit cycle is checked first, so it beats the timeout.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start || (AUTO_START && first_cycle)) begin
          launch     = 1'b1;
          state_next = ST_REQ_ID;
        end
      end
      ST_REQ_ID: begin
        if (accept && !USE_READDATAVALID) begin
          cap_id     = 1'b1;
          state_next = ST_REQ_TS;
        end else if (to_hit) begin
          abort      = 1'b1;
          state_next = ST_DONE;
        end else if (accept) begin
          state_next = ST_WAIT_ID;
        end
      end
      ST_WAIT_ID: begin
        if (avm_readdatavalid) begin
          cap_id     = 1'b1;
          state_next = ST_REQ_TS;
        end else if (to_hit) begin
          abort      = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_REQ_TS: begin
        if (accept && !USE_READDATAVALID) begin
          cap_ts     = 1'b1;
          state_next = ST_DONE;
        end else if (to_hit) begin
          abort      = 1'b1;
          state_next = ST_DONE;
        end else if (accept) begin
          state_next = ST_WAIT_TS;
        end
      end
      ST_WAIT_TS: begin
        if (avm_readdatavalid) begin
          cap_ts     = 1'b1;
          state_next = ST_DONE;
        end else if (to_hit) begin
          abort      = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = ST_REQ_ID;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The verdict is formed while the timestamp is being captured, using the
  // already registered ID and the live read data.
  assign ts_ok  = !CHECK_TIMESTAMP || (avm_readdata == EXPECTED_TIMESTAMP);
  assign run_ok = (sysid_id == EXPECTED_ID) && ts_ok && !timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      first_cycle     <= 1'b1;
      pass            <= 1'b0;
      fail            <= 1'b0;
      timeout         <= 1'b0;
      sysid_id        <= '0;
      sysid_timestamp <= '0;
    end else begin
      first_cycle <= 1'b0;
      if (launch) begin
        pass            <= 1'b0;
        fail            <= 1'b0;
        timeout         <= 1'b0;
        sysid_id        <= '0;
        sysid_timestamp <= '0;
      end
      if (cap_id) begin
        sysid_id <= avm_readdata;
      end
      if (cap_ts) begin
        sysid_timestamp <= avm_readdata;
        pass            <= run_ok;
        fail            <= !run_ok;
      end
      if (abort) begin
        timeout <= 1'b1;
        fail    <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: DUT A (data in accept cycle, timestamp
// checked, 10-cycle timeout) and DUT B (readdatavalid, timestamp not checked)
// share clock and reset, each with its own behavioural system-ID slave.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'hDEADBEEF;
  localparam logic [31:0] EXP_TS = 32'h5B95D975;
  localparam int RW = 67;  // {timeout, fail, pass, id, ts}

  logic clock;
  logic reset;
  logic start_a, start_b;

  logic        a_addr, a_read, a_wait, a_rdv;
  logic [31:0] a_rdata;
  logic        a_busy, a_done, a_pass, a_fail, a_to;
  logic [31:0] a_id, a_ts;

  logic        b_addr, b_read, b_wait, b_rdv;
  logic [31:0] b_rdata;
  logic        b_busy, b_done, b_pass, b_fail, b_to;
  logic [31:0] b_id, b_ts;

  // slave behaviour knobs
  int          stall_cycles;
  int          rdv_dly;
  bit          stuck;
  logic [31:0] id_val, ts_val;

  int errors = 0;
  int checks = 0;

  logic [31:0]   exp_addr_a[$];
  logic [31:0]   exp_addr_b[$];
  logic [RW-1:0] exp_q_a[$];
  logic [RW-1:0] exp_q_b[$];

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUTs ----------------
  sysid_boot_checker #(
    .CHECK_TIMESTAMP  (1'b1),
    .USE_READDATAVALID(1'b0),
    .TIMEOUT_CYCLES   (10),
    .AUTO_START       (1'b1)
  ) dut_a (
    .clock             (clock),
    .reset             (reset),
    .start             (start_a),
    .avm_address       (a_addr),
    .avm_read          (a_read),
    .avm_waitrequest   (a_wait),
    .avm_readdatavalid (a_rdv),
    .avm_readdata      (a_rdata),
    .busy              (a_busy),
    .done              (a_done),
    .pass              (a_pass),
    .fail              (a_fail),
    .timeout           (a_to),
    .sysid_id          (a_id),
    .sysid_timestamp   (a_ts)
  );

  sysid_boot_checker #(
    .CHECK_TIMESTAMP  (1'b0),
    .USE_READDATAVALID(1'b1),
    .TIMEOUT_CYCLES   (255),
    .AUTO_START       (1'b1)
  ) dut_b (
    .clock             (clock),
    .reset             (reset),
    .start             (start_b),
    .avm_address       (b_addr),
    .avm_read          (b_read),
    .avm_waitrequest   (b_wait),
    .avm_readdatavalid (b_rdv),
    .avm_readdata      (b_rdata),
    .busy              (b_busy),
    .done              (b_done),
    .pass              (b_pass),
    .fail              (b_fail),
    .timeout           (b_to),
    .sysid_id          (b_id),
    .sysid_timestamp   (b_ts)
  );

  // ---------------- slave A: data in accept cycle ----------------
  int stall_a;
  assign a_wait  = stuck || (a_read && (stall_a < stall_cycles));
  assign a_rdata = a_addr ? ts_val : id_val;
  assign a_rdv   = 1'b0;

  always @(posedge clock) begin
    if (reset || !a_read || !a_wait) stall_a <= 0;
    else stall_a <= stall_a + 1;
  end

  // ---------------- slave B: readdatavalid rdv_dly cycles after accept ----------------
  int   stall_b;
  bit   pend_b;
  int   dly_b;
  logic paddr_b;
  assign b_wait  = b_read && (stall_b < stall_cycles);
  assign b_rdv   = pend_b && (dly_b == 1);
  assign b_rdata = b_rdv ? (paddr_b ? ts_val : id_val) : 32'h0BAD0BAD;

  always @(posedge clock) begin
    if (reset || !b_read || !b_wait) stall_b <= 0;
    else stall_b <= stall_b + 1;
    if (reset) begin
      pend_b <= 1'b0;
      dly_b  <= 0;
    end else if (b_read && !b_wait) begin
      pend_b  <= 1'b1;
      dly_b   <= rdv_dly;
      paddr_b <= b_addr;
    end else if (pend_b) begin
      if (dly_b == 1) pend_b <= 1'b0;
      dly_b <= dly_b - 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_res(input logic t, input logic f, input logic p,
                                           input logic [31:0] id, input logic [31:0] ts);
    return {t, f, p, id, ts};
  endfunction

  // accepted reads are compared with the expected address queue; a stalled
  // request must hold read and address until it is accepted
  bit          a_stall_prev, b_stall_prev;
  logic [31:0] a_stall_addr, b_stall_addr;

  always @(negedge clock) begin
    if (a_read && !a_wait) begin
      if (exp_addr_a.size() == 0) chk("a_unexpected_read", 32'(a_addr), 32'hFFFF_FFFF);
      else chk("a_read_addr", 32'(a_addr), exp_addr_a.pop_front());
    end
    if (b_read && !b_wait) begin
      if (exp_addr_b.size() == 0) chk("b_unexpected_read", 32'(b_addr), 32'hFFFF_FFFF);
      else chk("b_read_addr", 32'(b_addr), exp_addr_b.pop_front());
    end
    if (a_stall_prev && !reset) begin
      chk("a_stall_read", 32'(a_read), 32'd1);
      chk("a_stall_addr", 32'(a_addr), a_stall_addr);
    end
    if (b_stall_prev && !reset) begin
      chk("b_stall_read", 32'(b_read), 32'd1);
      chk("b_stall_addr", 32'(b_addr), b_stall_addr);
    end
    a_stall_prev = a_read && a_wait && !stuck;
    a_stall_addr = 32'(a_addr);
    b_stall_prev = b_read && b_wait;
    b_stall_addr = 32'(b_addr);
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int d);
    @(negedge clock);
    if (d == 0) start_a = 1'b1;
    else start_b = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // counts busy and read cycles until done, bounded by budget
  task automatic wait_done(input int d, input int budget, output int busy_cyc,
                           output int read_cyc, output bit ok);
    busy_cyc = 0;
    read_cyc = 0;
    ok       = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if ((d == 0) ? a_done : b_done) begin
        ok = 1'b1;
        break;
      end
      if ((d == 0) ? a_busy : b_busy) busy_cyc++;
      if ((d == 0) ? a_read : b_read) read_cyc++;
    end
  endtask

  task automatic check_result(input int d, input string tag);
    logic [RW-1:0] e;
    checks++;
    assert (((d == 0) ? exp_q_a.size() : exp_q_b.size()) != 0) else begin
      errors++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
      return;
    end
    e = (d == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
    if (d == 0) begin
      chk({tag, "_done"},    32'(a_done), 32'd1);
      chk({tag, "_busy"},    32'(a_busy), 32'd0);
      chk({tag, "_timeout"}, 32'(a_to),   32'(e[66]));
      chk({tag, "_fail"},    32'(a_fail), 32'(e[65]));
      chk({tag, "_pass"},    32'(a_pass), 32'(e[64]));
      chk({tag, "_id"},      a_id,        e[63:32]);
      chk({tag, "_ts"},      a_ts,        e[31:0]);
    end else begin
      chk({tag, "_done"},    32'(b_done), 32'd1);
      chk({tag, "_busy"},    32'(b_busy), 32'd0);
      chk({tag, "_timeout"}, 32'(b_to),   32'(e[66]));
      chk({tag, "_fail"},    32'(b_fail), 32'(e[65]));
      chk({tag, "_pass"},    32'(b_pass), 32'(e[64]));
      chk({tag, "_id"},      b_id,        e[63:32]);
      chk({tag, "_ts"},      b_ts,        e[31:0]);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_a_read"}, 32'(a_read), 32'd0);
    chk({tag, "_a_addr"}, 32'(a_addr), 32'd0);
    chk({tag, "_a_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_a_flags"}, {28'd0, a_done, a_pass, a_fail, a_to}, 32'd0);
    chk({tag, "_a_id"}, a_id, 32'd0);
    chk({tag, "_a_ts"}, a_ts, 32'd0);
    chk({tag, "_b_read"}, 32'(b_read), 32'd0);
    chk({tag, "_b_addr"}, 32'(b_addr), 32'd0);
    chk({tag, "_b_busy"}, 32'(b_busy), 32'd0);
    chk({tag, "_b_flags"}, {28'd0, b_done, b_pass, b_fail, b_to}, 32'd0);
    chk({tag, "_b_id"}, b_id, 32'd0);
    chk({tag, "_b_ts"}, b_ts, 32'd0);
  endtask

  task automatic push_run(input int d, input logic [RW-1:0] res);
    if (d == 0) begin
      exp_addr_a.push_back(32'd0);
      exp_addr_a.push_back(32'd1);
      exp_q_a.push_back(res);
    end else begin
      exp_addr_b.push_back(32'd0);
      exp_addr_b.push_back(32'd1);
      exp_q_b.push_back(res);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bc_a, rc_a, bc_b, rc_b, n;
    bit ok_a, ok_b;

    reset        = 1'b1;
    start_a      = 1'b0;
    start_b      = 1'b0;
    stuck        = 1'b0;
    stall_cycles = 0;
    rdv_dly      = 2;
    id_val       = EXP_ID;
    ts_val       = EXP_TS;
    repeat (3) @(negedge clock);
    check_reset("rst");

    // auto-start on reset release, zero-wait slaves
    push_run(0, mk_res(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS));
    push_run(1, mk_res(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS));
    reset = 1'b0;
    fork
      wait_done(0, 20, bc_a, rc_a, ok_a);
      wait_done(1, 30, bc_b, rc_b, ok_b);
    join
    chk("auto_a_done_seen", 32'(ok_a), 32'd1);
    chk("auto_a_busy_cycles", bc_a, 32'd2);
    chk("auto_a_read_cycles", rc_a, 32'd2);
    chk("auto_b_done_seen", 32'(ok_b), 32'd1);
    chk("auto_b_busy_cycles", bc_b, 32'd6);
    chk("auto_b_read_cycles", rc_b, 32'd2);
    check_result(0, "auto_a");
    check_result(1, "auto_b");
    // no second auto-launch without a start
    repeat (3) @(negedge clock);
    chk("no_relaunch_a_busy", 32'(a_busy), 32'd0);
    chk("no_relaunch_a_done", 32'(a_done), 32'd1);

    // three stall cycles on each read
    stall_cycles = 3;
    push_run(0, mk_res(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS));
    pulse_start(0);
    wait_done(0, 30, bc_a, rc_a, ok_a);
    chk("stall_a_done_seen", 32'(ok_a), 32'd1);
    chk("stall_a_busy_cycles", bc_a, 32'd8);
    chk("stall_a_read_cycles", rc_a, 32'd8);
    check_result(0, "stall_a");
    stall_cycles = 0;

    // wrong ID: timestamp still read, run fails
    id_val = 32'h12345678;
    push_run(0, mk_res(1'b0, 1'b1, 1'b0, 32'h12345678, EXP_TS));
    pulse_start(0);
    wait_done(0, 20, bc_a, rc_a, ok_a);
    chk("bad_id_a_done_seen", 32'(ok_a), 32'd1);
    chk("bad_id_a_busy_cycles", bc_a, 32'd2);
    check_result(0, "bad_id_a");
    id_val = EXP_ID;

    // wrong timestamp: fails on A (checked), passes on B (not checked)
    ts_val = 32'h22222222;
    push_run(0, mk_res(1'b0, 1'b1, 1'b0, EXP_ID, 32'h22222222));
    pulse_start(0);
    wait_done(0, 20, bc_a, rc_a, ok_a);
    chk("bad_ts_a_done_seen", 32'(ok_a), 32'd1);
    check_result(0, "bad_ts_a");
    ts_val = 32'h11111111;
    push_run(1, mk_res(1'b0, 1'b0, 1'b1, EXP_ID, 32'h11111111));
    pulse_start(1);
    wait_done(1, 30, bc_b, rc_b, ok_b);
    chk("nochk_ts_b_done_seen", 32'(ok_b), 32'd1);
    chk("nochk_ts_b_read_cycles", rc_b, 32'd2);
    check_result(1, "nochk_ts_b");
    ts_val = EXP_TS;

    // waitrequest stuck: abort after 10 request cycles
    stuck = 1'b1;
    exp_q_a.push_back(mk_res(1'b1, 1'b1, 1'b0, 32'd0, 32'd0));
    pulse_start(0);
    wait_done(0, 40, bc_a, rc_a, ok_a);
    chk("to_a_done_seen", 32'(ok_a), 32'd1);
    chk("to_a_read_cycles", rc_a, 32'd10);
    chk("to_a_busy_cycles", bc_a, 32'd10);
    check_result(0, "to_a");
    stuck = 1'b0;

    // healthy rerun after the timeout clears status
    push_run(0, mk_res(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS));
    pulse_start(0);
    wait_done(0, 20, bc_a, rc_a, ok_a);
    chk("rerun_a_done_seen", 32'(ok_a), 32'd1);
    check_result(0, "rerun_a");

    // start pulse while busy has no effect
    stall_cycles = 3;
    push_run(0, mk_res(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS));
    pulse_start(0);
    fork
      wait_done(0, 30, bc_a, rc_a, ok_a);
      begin
        repeat (2) @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
      end
    join
    chk("busy_start_a_done_seen", 32'(ok_a), 32'd1);
    chk("busy_start_a_busy_cycles", bc_a, 32'd8);
    check_result(0, "busy_start_a");
    stall_cycles = 0;

    // reset while B waits for the timestamp data, then auto rerun
    exp_addr_b.push_back(32'd0);
    exp_addr_b.push_back(32'd1);
    pulse_start(1);
    n = 0;
    while (!(b_busy && !b_read && b_addr) && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("mid_b_wait_ts_seen", 32'(n < 20), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_reset("mid_rst");
    push_run(0, mk_res(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS));
    push_run(1, mk_res(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS));
    reset = 1'b0;
    fork
      wait_done(0, 20, bc_a, rc_a, ok_a);
      wait_done(1, 30, bc_b, rc_b, ok_b);
    join
    chk("post_rst_a_done_seen", 32'(ok_a), 32'd1);
    chk("post_rst_b_done_seen", 32'(ok_b), 32'd1);
    chk("post_rst_b_busy_cycles", bc_b, 32'd6);
    check_result(0, "post_rst_a");
    check_result(1, "post_rst_b");

    @(negedge clock);
    chk("a_addr_q_drained", exp_addr_a.size(), 32'd0);
    chk("b_addr_q_drained", exp_addr_b.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
